reg_load_rr_arbiter: RTL and testbench
======================================

// Module: reg_load_rr_arbiter
// PURPOSE
//   Shares one load-enable D register among NUM_REQ requesters with round-robin arbitration.
//   Each transaction runs a fixed 4-state sequence: grant, load-enable pulse, register update, ack.
//   The block is the controller that sits in front of the shared flip-flop bank.
//   It is the only source of that bank's d/en inputs.
// PARAMETERS
//   NUM_REQ  4  number of requesters, 2..8
//   DATA_W   8  width of the shared register and of each requester data lane
// PORTS
//   clk          in   1               rising-edge clock
//   reset_ah_in  in   1               asynchronous, active-high reset
//   req_in       in   NUM_REQ         per-requester load request, level
//   data_in      in   NUM_REQ*DATA_W  lane i = data_in[i*DATA_W +: DATA_W]
//   gnt_out      out  NUM_REQ         one-hot grant, registered
//   en_out       out  1               load-enable pulse to the shared register
//   q_out        out  DATA_W          shared register contents
//   ack_out      out  NUM_REQ         one-hot, one-cycle completion pulse
//   owner_out    out  clog2(NUM_REQ)  index of last/current winner
// BEHAVIOUR
//   Reset (async, any state):
//     state=IDLE, rr pointer=0
//     gnt_out=0, en_out=0, ack_out=0, q_out=0, owner_out=0
//   FSM states and transitions:
//     IDLE -> ARB when |req_in.
//       - Winner = first set req_in bit searching from pointer upward, wrapping NUM_REQ-1 -> 0.
//       - gnt_out[winner] and owner_out are registered on entry to ARB.
//     ARB -> LOAD if req_in[owner] is still 1.
//     ARB -> IDLE if req_in[owner] is 0: abort, no load, no ack, pointer unchanged.
//     LOAD: en_out=1 for exactly this cycle.
//       - q_out <= data lane[owner] on the edge leaving LOAD.
//       - A req drop during LOAD does not abort the load.
//     LOAD -> DONE: ack_out[owner]=1, gnt_out held, q_out holds the new value.
//     DONE -> IDLE: gnt_out=0, pointer <= (owner+1) mod NUM_REQ.
//   Latency and throughput:
//     - req seen at edge k -> gnt at k+1, en at k+2, q/ack at k+3, IDLE at k+4.
//     - One load per 4 cycles maximum; no IDLE bypass.
//   Handshake:
//     - Requester holds req_in and data lane stable from req rise until ack_out.
//     - It may re-request the cycle after ack; round-robin then favours other requesters.
//   Output invariants:
//     - q_out changes only on the edge after en_out=1.
//     - gnt_out and ack_out are always one-hot or zero.
//     - en_out never asserts outside LOAD.
//   Simultaneous requests: only the pointer-order winner is served; the others wait, no loss.
//   Pointer wrap: owner=NUM_REQ-1 -> pointer 0.
//   Reset during LOAD: en_out drops immediately, q_out=0, no ack issued.
// CONFIGURATION
//   LOAD_LOCK_EN defined:
//     - Adds port lock_in (in, NUM_REQ).
//     - If lock_in[owner]=1 in DONE and req_in[owner]=1 in the following IDLE,
//       the next grant goes to owner again and the pointer is not advanced.
//     - Releasing lock_in resumes normal rotation.
//   LOAD_LOCK_EN undefined: no lock_in port; pointer always advances in DONE.
// TESTING
//   T1 reset mid-LOAD:
//     - Stimulus: assert reset_ah_in while en_out=1.
//     - Required: all outputs 0 within the same cycle, FSM in IDLE.
//   T2 single requester:
//     - Stimulus: req_in=4'b0010, lane1=8'hA5.
//     - Required: gnt=0010 at +1, en at +2, q_out=A5 and ack=0010 at +3.
//   T3 all requesters held high, NUM_REQ=4, from reset:
//     - Required: acks in order 0,1,2,3,0.
//     - Required: q_out follows lanes 0..3; one ack per 4 cycles.
//   T4 abort:
//     - Stimulus: req_in[2] drops during ARB.
//     - Required: no en_out, no ack, q_out unchanged, next winner still searched from the same pointer.
//   T5 wrap:
//     - Stimulus: only req 3 then req 0.
//     - Required: owner_out 3 then 0; pointer returns to 1.
//   T6 with LOAD_LOCK_EN:
//     - Stimulus: lock_in[1]=1, req 1 and req 2 both high.
//     - Required: three consecutive grants to 1; after lock release, the next grant goes to 2.

Source files
------------

// File: rtl/reg_load_rr_arbiter_if.sv
// Bus between the requesters and the shared load-register controller.
// The lock_in lane exists only when LOAD_LOCK_EN is defined.
interface reg_load_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a requester raises req_in[i] and holds it and its data lane stable
    // until ack_out[i] pulses. Dropping req_in[i] while granted but before LOAD aborts
    // that transaction; a drop during LOAD is ignored. It may re-request after ack.
    logic [NUM_REQ-1:0]        req_in;
    logic [NUM_REQ*DATA_W-1:0] data_in;
    logic [NUM_REQ-1:0]        gnt_out;
    logic                      en_out;
    logic [DATA_W-1:0]         q_out;
    logic [NUM_REQ-1:0]        ack_out;
    logic [OW-1:0]             owner_out;
    logic [1:0]                state_dbg;
`ifdef LOAD_LOCK_EN
    logic [NUM_REQ-1:0]        lock_in;

    modport slave  (input  req_in, data_in, lock_in,
                    output gnt_out, en_out, q_out, ack_out, owner_out, state_dbg);
    modport master (output req_in, data_in, lock_in,
                    input  gnt_out, en_out, q_out, ack_out, owner_out, state_dbg);
`else
    modport slave  (input  req_in, data_in,
                    output gnt_out, en_out, q_out, ack_out, owner_out, state_dbg);
    modport master (output req_in, data_in,
                    input  gnt_out, en_out, q_out, ack_out, owner_out, state_dbg);
`endif
endinterface

// File: rtl/reg_load_rr_arbiter.sv
// Round-robin controller for one shared load-enable register: grant, load pulse, update, ack.
// Optional LOAD_LOCK_EN lets the current owner keep the register across back-to-back loads.
module reg_load_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input logic                  clk,
    input logic                  reset_ah_in,
    reg_load_rr_arbiter_if.slave bus
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, LOAD = 2'd2, DONE = 2'd3} state_t;

    state_t             state, state_nxt;
    logic [OW-1:0]      ptr, owner, owner_inc, base, win_idx, cand_idx;
    logic [NUM_REQ-1:0] gnt, win_onehot, req;
    logic [DATA_W-1:0]  q;
    logic [DATA_W-1:0]  lanes [NUM_REQ];
    logic               win_found;
    int                 cand;

    assign req = bus.req_in;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lanes[g] = bus.data_in[g*DATA_W +: DATA_W];
    end

    assign owner_inc = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);

`ifdef LOAD_LOCK_EN
    logic lock_hold;
    // While a lock is pending the pointer was not advanced, so an unlocked
    // search must still start just past the owner.
    assign base = lock_hold ? owner_inc : ptr;
`else
    assign base = ptr;
`endif

    // Walk downward so the lowest offset from base (the first in rotation) wins last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(base) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = OW'(cand);
            if (req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
`ifdef LOAD_LOCK_EN
        if (lock_hold && req[owner]) begin
            win_found = 1'b1;
            win_idx   = owner;
        end
`endif
    end

    assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;

    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = ARB;
            ARB:     state_nxt = req[owner] ? LOAD : IDLE;
            LOAD:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            gnt   <= '0;
            owner <= '0;
            ptr   <= '0;
            q     <= '0;
`ifdef LOAD_LOCK_EN
            lock_hold <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (win_found) begin
                    gnt   <= win_onehot;
                    owner <= win_idx;
`ifdef LOAD_LOCK_EN
                    lock_hold <= 1'b0;
`endif
                end
                ARB:  if (!req[owner]) gnt <= '0;
                LOAD: q <= lanes[owner];
                DONE: begin
                    gnt <= '0;
`ifdef LOAD_LOCK_EN
                    if (bus.lock_in[owner]) lock_hold <= 1'b1;
                    else                    ptr       <= owner_inc;
`else
                    ptr <= owner_inc;
`endif
                end
                default: gnt <= '0;
            endcase
        end
    end

    assign bus.gnt_out   = gnt;
    assign bus.en_out    = (state == LOAD);
    assign bus.ack_out   = (state == DONE) ? gnt : '0;
    assign bus.q_out     = q;
    assign bus.owner_out = owner;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_reg_load_rr_arbiter.sv
// Directed bench for reg_load_rr_arbiter: reset, single request, abort, wrap,
// reset during LOAD, full round-robin rotation, and (with LOAD_LOCK_EN) owner lock.
module tb_reg_load_rr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] lane_v [NUM_REQ];

    reg_load_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    reg_load_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset_ah_in (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_outs(input string tag, input logic [3:0] gnt, input logic en,
                              input logic [3:0] ack, input logic [7:0] q);
        check({tag, "_gnt"}, 32'(bus.gnt_out), 32'(gnt));
        check({tag, "_en"},  32'(bus.en_out),  32'(en));
        check({tag, "_ack"}, 32'(bus.ack_out), 32'(ack));
        check({tag, "_q"},   32'(bus.q_out),   32'(q));
    endtask

    initial begin
        lane_v[0] = 8'h11;
        lane_v[1] = 8'hA5;
        lane_v[2] = 8'h33;
        lane_v[3] = 8'h44;
        rst         = 1'b1;
        bus.req_in  = '0;
        for (int i = 0; i < NUM_REQ; i++) bus.data_in[i*DATA_W +: DATA_W] = lane_v[i];
`ifdef LOAD_LOCK_EN
        bus.lock_in = '0;
`endif
        @(negedge clk);
        check_outs("reset", 4'b0000, 1'b0, 4'b0000, 8'h00);
        check("reset_owner", 32'(bus.owner_out), 32'd0);
        check("reset_state", 32'(bus.state_dbg), 32'd0);
        rst = 1'b0;
        cyc(1);
        check("idle_state", 32'(bus.state_dbg), 32'd0);

        // T2 single requester 1, pointer 0 -> 2
        bus.req_in = 4'b0010;
        cyc(1); check_outs("t2_arb", 4'b0010, 1'b0, 4'b0000, 8'h00);
        check("t2_owner", 32'(bus.owner_out), 32'd1);
        cyc(1); check_outs("t2_load", 4'b0010, 1'b1, 4'b0000, 8'h00);
        cyc(1); check_outs("t2_done", 4'b0010, 1'b0, 4'b0010, 8'hA5);
        bus.req_in = 4'b0000;
        cyc(1); check_outs("t2_idle", 4'b0000, 1'b0, 4'b0000, 8'hA5);
        check("t2_state", 32'(bus.state_dbg), 32'd0);

        // T4 abort of requester 2; pointer must stay 2
        bus.req_in = 4'b0100;
        cyc(1); check_outs("t4_arb", 4'b0100, 1'b0, 4'b0000, 8'hA5);
        bus.req_in = 4'b0000;
        cyc(1); check_outs("t4_abort", 4'b0000, 1'b0, 4'b0000, 8'hA5);
        check("t4_state", 32'(bus.state_dbg), 32'd0);
        cyc(1); check_outs("t4_still", 4'b0000, 1'b0, 4'b0000, 8'hA5);
        bus.req_in = 4'b0110;
        cyc(1); check("t4_reowner", 32'(bus.owner_out), 32'd2);
        check("t4_regnt", 32'(bus.gnt_out), 32'h4);
        cyc(1); check("t4_load_en", 32'(bus.en_out), 32'd1);
        cyc(1); check_outs("t4_done", 4'b0100, 1'b0, 4'b0100, 8'h33);
        bus.req_in = 4'b0000;
        cyc(1);

        // T5 wrap: requester 3 then 0, pointer back to 1
        bus.req_in = 4'b1000;
        cyc(1); check("t5_owner3", 32'(bus.owner_out), 32'd3);
        cyc(2); check_outs("t5_done3", 4'b1000, 1'b0, 4'b1000, 8'h44);
        bus.req_in = 4'b0000;
        cyc(1);
        bus.req_in = 4'b0001;
        cyc(1); check("t5_owner0", 32'(bus.owner_out), 32'd0);
        cyc(2); check_outs("t5_done0", 4'b0001, 1'b0, 4'b0001, 8'h11);
        bus.req_in = 4'b0000;
        cyc(1);
        bus.req_in = 4'b0011;
        cyc(1); check("t5_ptr1", 32'(bus.owner_out), 32'd1);
        check("t5_gnt1", 32'(bus.gnt_out), 32'h2);

        // T1 reset while en_out is high
        cyc(1); check("t1_en_before", 32'(bus.en_out), 32'd1);
        rst = 1'b1;
        #1;
        check_outs("t1_rst", 4'b0000, 1'b0, 4'b0000, 8'h00);
        check("t1_state", 32'(bus.state_dbg), 32'd0);
        check("t1_owner", 32'(bus.owner_out), 32'd0);
        bus.req_in = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        cyc(1); check_outs("t1_after", 4'b0000, 1'b0, 4'b0000, 8'h00);

        // T3 all requesters high from reset: acks 0,1,2,3,0, one per 4 cycles
        for (int t = 0; t < 5; t++) exp_q.push_back(lane_v[t % NUM_REQ]);
        bus.req_in = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            cyc(1);
            check("t3_arb_state", 32'(bus.state_dbg), 32'd1);
            check("t3_owner", 32'(bus.owner_out), 32'(t % NUM_REQ));
            check("t3_arb_ack", 32'(bus.ack_out), 32'd0);
            cyc(1); check("t3_en", 32'(bus.en_out), 32'd1);
            check("t3_load_ack", 32'(bus.ack_out), 32'd0);
            cyc(1);
            check("t3_ack", 32'(bus.ack_out), 32'(4'b0001 << (t % NUM_REQ)));
            check("t3_q", 32'(bus.q_out), 32'(exp_q.pop_front()));
            cyc(1);
            check("t3_idle_state", 32'(bus.state_dbg), 32'd0);
            check("t3_idle_ack", 32'(bus.ack_out), 32'd0);
        end
        bus.req_in = 4'b0000;
        cyc(1);

`ifdef LOAD_LOCK_EN
        // T6 lock on requester 1: three grants to 1, then rotation resumes at 2
        bus.lock_in = 4'b0010;
        bus.req_in  = 4'b0110;
        for (int g = 0; g < 3; g++) begin
            cyc(1); check("t6_owner1", 32'(bus.owner_out), 32'd1);
            cyc(1);
            if (g == 2) bus.lock_in = 4'b0000;
            cyc(1); check("t6_ack1", 32'(bus.ack_out), 32'h2);
            cyc(1);
        end
        cyc(1); check("t6_owner2", 32'(bus.owner_out), 32'd2);
        bus.req_in = 4'b0000;
        cyc(3);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
